// File: rtl/imm_extend_ctrl.sv
// imm_extend_ctrl: immediate generation sequencer for the RISC-V core.
// Accepts a 32-bit instruction word over valid/ready and decodes its opcode
// into one of the R/I/S/B/U/J formats. It assembles and sign-extends the
// immediate field, then holds the result until the consumer accepts it.
// FSM: IDLE (accept) -> EXT (decode and register) -> OUT (present result).
// Optional feature macro: IMM_COUNT_EN adds the imm_count port. This is a
// saturating count of delivered results, and illegal results are included.

module imm_extend_ctrl #(
    parameter int XLEN = 32
`ifdef IMM_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
`ifdef IMM_COUNT_EN
    ,
    output logic [CNT_W-1:0] imm_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXT  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Sign extension replicates the top bit of the assembled field.
    function automatic logic [31:0] sext12(input logic [11:0] f);
        sext12 = {{20{f[11]}}, f};
    endfunction

    function automatic logic [31:0] sext13(input logic [12:0] f);
        sext13 = {{19{f[12]}}, f};
    endfunction

    function automatic logic [31:0] sext21(input logic [20:0] f);
        sext21 = {{11{f[20]}}, f};
    endfunction

    logic [1:0]      state_q,     state_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] instr_q,     instr_d;
    logic [XLEN-1:0] imm_q,       imm_d;
    logic [2:0]      fmt_q,       fmt_d;
    logic            illegal_q,   illegal_d;

    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_fmt_s;
    logic            dec_illegal_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;

    assign opcode_s = instr_q[6:0];
    assign funct3_s = instr_q[14:12];

    // Decode the captured instruction word into its immediate and format.
    always_comb begin
        dec_imm_s     = 32'h0000_0000;
        dec_fmt_s     = FMT_ILL;
        dec_illegal_s = 1'b1;
        case (opcode_s)
            OP_OP_IMM: begin
                dec_fmt_s     = FMT_I;
                dec_illegal_s = 1'b0;
                // Shift instructions carry an unsigned shift amount in [24:20].
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    dec_imm_s = {27'd0, instr_q[24:20]};
                end else begin
                    dec_imm_s = sext12(instr_q[31:20]);
                end
            end
            OP_LOAD, OP_JALR: begin
                dec_fmt_s     = FMT_I;
                dec_illegal_s = 1'b0;
                dec_imm_s     = sext12(instr_q[31:20]);
            end
            OP_STORE: begin
                dec_fmt_s     = FMT_S;
                dec_illegal_s = 1'b0;
                dec_imm_s     = sext12({instr_q[31:25], instr_q[11:7]});
            end
            OP_BRANCH: begin
                dec_fmt_s     = FMT_B;
                dec_illegal_s = 1'b0;
                dec_imm_s     = sext13({instr_q[31], instr_q[7], instr_q[30:25],
                                        instr_q[11:8], 1'b0});
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt_s     = FMT_U;
                dec_illegal_s = 1'b0;
                dec_imm_s     = {instr_q[31:12], 12'h000};
            end
            OP_JAL: begin
                dec_fmt_s     = FMT_J;
                dec_illegal_s = 1'b0;
                dec_imm_s     = sext21({instr_q[31], instr_q[19:12], instr_q[20],
                                        instr_q[30:21], 1'b0});
            end
            OP_OP: begin
                dec_fmt_s     = FMT_R;
                dec_illegal_s = 1'b0;
                dec_imm_s     = 32'h0000_0000;
            end
            default: begin
                dec_fmt_s     = FMT_ILL;
                dec_illegal_s = 1'b1;
                dec_imm_s     = 32'h0000_0000;
            end
        endcase
    end

    // Sequencing FSM: capture in IDLE, register the decode in EXT, hold in OUT.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    instr_d = in_instr;
                    state_d = ST_EXT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXT: begin
                imm_d     = dec_imm_s;
                fmt_d     = dec_fmt_s;
                illegal_d = dec_illegal_s;
                state_d   = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake flags are registered from the next state so they track it exactly.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
    end

    // State and result registers; reset discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= 32'h0000_0000;
            imm_q       <= 32'h0000_0000;
            fmt_q       <= 3'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            fmt_q       <= fmt_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign imm       = imm_q;
    assign fmt       = fmt_q;
    assign illegal   = illegal_q;

`ifdef IMM_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Saturating count of delivered results, illegal ones included.
    always_comb begin
        if (out_valid_q && out_ready && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Delivered-result counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign imm_count = count_q;
`endif

endmodule
